// File: rtl/seq_divider.sv
// Restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// Valid/ready on both sides; in_ready only in IDLE, result held in DONE until out_ready.
module seq_divider #(
  parameter int N = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*N-1:0]   dividend,
  input  logic [N-1:0]     divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   quotient,
  output logic [N-1:0]     remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(2*N);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt;
  logic [2*N-1:0] work;      // dividend bits leave at the MSB, quotient bits enter at the LSB
  logic [N-1:0]   dsr;
  logic [N:0]     prem;
  logic           zero_div;

  logic [N+1:0]   trial;
  logic           fits;
  logic [N:0]     prem_nxt;
  logic [2*N-1:0] work_nxt;

  always_comb begin
    trial    = {prem, work[2*N-1]};
    fits     = trial >= (N+2)'(dsr);
    prem_nxt = fits ? (N+1)'(trial - (N+2)'(dsr)) : (N+1)'(trial);
    work_nxt = {work[2*N-2:0], fits};
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = CALC;
      end
      CALC: begin
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A zero divisor still passes through one CALC cycle, so its result appears one cycle after accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      work        <= '0;
      dsr         <= '0;
      prem        <= '0;
      zero_div    <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            work     <= dividend;
            dsr      <= divisor;
            prem     <= '0;
            zero_div <= (divisor == '0);
            cnt      <= (divisor == '0) ? '0 : CW'(2*N-1);
          end
        end
        CALC: begin
          cnt <= cnt - 1'b1;
          if (zero_div) begin
            quotient    <= '1;
            remainder   <= work[N-1:0];
            div_by_zero <= 1'b1;
          end else begin
            prem <= prem_nxt;
            work <= work_nxt;
            if (cnt == '0) begin
              quotient    <= work_nxt;
              remainder   <= prem_nxt[N-1:0];
              div_by_zero <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed table, handshake/reset sequences, random round-trip and streaming.
module tb_seq_divider;

  localparam int N = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [15:0]   dividend = '0;
  logic [7:0]    divisor = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [15:0]   quotient;
  logic [7:0]    remainder;
  logic          div_by_zero;

  int errors = 0;
  int checks = 0;

  seq_divider #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] dd;
    logic [7:0]  dv;
    logic [15:0] q;
    logic [7:0]  r;
    logic        z;
    int          lat;
  } vec_t;

  typedef struct {
    logic [15:0] dd;
    logic [7:0]  dv;
    int          cyc;
  } pend_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Result as {div_by_zero, remainder, quotient}, straight from the arithmetic definition.
  function automatic logic [24:0] ref_div(input logic [15:0] dd, input logic [7:0] dv);
    logic [7:0] low;
    low = dd[7:0];
    if (dv == 8'd0) return {1'b1, low, 16'hFFFF};
    return {1'b0, 8'(dd % dv), 16'(dd / dv)};
  endfunction

  task automatic run_op(input logic [15:0] dd, input logic [7:0] dv,
                        output logic [15:0] q, output logic [7:0] r, output logic z,
                        output int lat);
    int t;
    t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1; t++;
    end
    dividend = dd; divisor = dv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    q = quotient; r = remainder; z = div_by_zero;
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    vec_t        tbl[7];
    logic [15:0] q;
    logic [7:0]  r;
    logic        z;
    int          lat;
    logic [7:0]  a, b;
    logic [15:0] p;
    pend_t       qp[$];
    pend_t       pe;
    int          cyc, nres;

    tbl[0] = '{16'h0064, 8'h07, 16'd14,   8'd2,  1'b0, 16};
    tbl[1] = '{16'hFFFF, 8'h01, 16'hFFFF, 8'd0,  1'b0, 16};
    tbl[2] = '{16'hFFFF, 8'hFF, 16'h0101, 8'd0,  1'b0, 16};
    tbl[3] = '{16'h0000, 8'h05, 16'h0000, 8'd0,  1'b0, 16};
    tbl[4] = '{16'h1234, 8'h00, 16'hFFFF, 8'h34, 1'b1, 1};
    tbl[5] = '{16'd200,  8'd3,  16'd66,   8'd2,  1'b0, 16};
    tbl[6] = '{16'h0007, 8'h64, 16'h0000, 8'h07, 1'b0, 16};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_outputs", {div_by_zero, remainder, quotient}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      run_op(tbl[i].dd, tbl[i].dv, q, r, z, lat);
      chk($sformatf("tbl%0d_latency", i), lat, tbl[i].lat);
      chk($sformatf("tbl%0d_quotient", i), q, tbl[i].q);
      chk($sformatf("tbl%0d_remainder", i), r, tbl[i].r);
      chk($sformatf("tbl%0d_dbz", i), z, tbl[i].z);
      take();
      chk($sformatf("tbl%0d_ready_after_take", i), in_ready, 1);
    end

    // Backpressure: result must hold and new operands must be ignored while DONE.
    run_op(16'h0064, 8'h07, q, r, z, lat);
    for (int i = 0; i < 10; i++) begin
      in_valid = (i == 4);
      dividend = 16'h0005; divisor = 8'h00;
      @(posedge clk); #1;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_result", {div_by_zero, remainder, quotient}, {1'b0, 8'd2, 16'd14});
    end
    in_valid = 1'b0;
    take();
    chk("bp_ready_after_take", in_ready, 1);
    chk("bp_result_held_idle", {div_by_zero, remainder, quotient}, {1'b0, 8'd2, 16'd14});
    repeat (3) @(posedge clk);
    #1;
    chk("bp_pulse_not_queued", {out_valid, in_ready}, 2'b01);

    // Reset in the 7th CALC cycle of 200/3.
    dividend = 16'd200; divisor = 8'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_outputs", {div_by_zero, remainder, quotient}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(16'd200, 8'd3, q, r, z, lat);
    chk("rst_fresh_latency", lat, 16);
    chk("rst_fresh_result", {z, r, q}, {1'b0, 8'd2, 16'd66});
    take();

    // Multiplier round trip: (a*b)/b must give a with zero remainder.
    for (int i = 0; i < 1500; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(1, 255));
      p = a * b;
      run_op(p, b, q, r, z, lat);
      chk("roundtrip", {z, r, q}, {1'b0, 8'd0, 8'd0, a});
      take();
    end

    // Streaming: in_valid and out_ready held high, operands change every cycle.
    in_valid = 1'b1; out_ready = 1'b1;
    cyc = 0; nres = 0;
    while ((nres < 600 || qp.size() > 0) && cyc < 20000) begin
      if (out_valid) begin
        if (qp.size() == 0) begin
          chk("stream_spurious_result", 1, 0);
        end else begin
          pe = qp.pop_front();
          chk("stream_result", {div_by_zero, remainder, quotient}, ref_div(pe.dd, pe.dv));
          chk("stream_latency", cyc - pe.cyc, (pe.dv == 8'd0) ? 2 : 17);
          nres++;
        end
      end
      in_valid = (nres < 600);
      dividend = 16'($urandom);
      divisor  = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
      if (in_valid && in_ready) qp.push_back('{dividend, divisor, cyc});
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("stream_complete", (nres >= 600) && (qp.size() == 0), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
